// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - move/result codes, judge states and move helpers
package game_pkg;

  typedef enum logic [1:0] {
    ROCK     = 2'b00,
    PAPER    = 2'b01,
    SCISSORS = 2'b10,
    ILLEGAL  = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_TIE  = 2'b11
  } result_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CPU_REQ,
    S_CPU_WAIT,
    S_JUDGE,
    S_DONE
  } state_e;

  // The move that beats m: (m + 1) mod 3
  function automatic logic [1:0] beater_of(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      ROCK:    r = PAPER;
      PAPER:   r = SCISSORS;
      default: r = ROCK;
    endcase
    return r;
  endfunction

  function automatic logic is_legal(input logic [1:0] m);
    return m != ILLEGAL;
  endfunction

endpackage

// File: rtl/round_judge_if.sv
// rtl/round_judge_if.sv - front-end/CPU/display signal bundle around the judge
interface round_judge_if #(
  parameter int SCORE_W = 3
);
  logic               start;
  logic               p2_is_cpu;
  logic [1:0]         p1_move;
  logic               p1_valid;
  logic [1:0]         p2_move;
  logic               p2_valid;
  logic               cpu_en;
  logic [1:0]         cpu_move;
  logic [1:0]         round_result;
  logic               result_valid;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               game_over;
  logic [1:0]         winner;
  logic               busy;

  modport master (
    output start, p2_is_cpu, p1_move, p1_valid, p2_move, p2_valid, cpu_move,
    input  cpu_en, round_result, result_valid, p1_score, p2_score,
           game_over, winner, busy
  );

  modport slave (
    input  start, p2_is_cpu, p1_move, p1_valid, p2_move, p2_valid, cpu_move,
    output cpu_en, round_result, result_valid, p1_score, p2_score,
           game_over, winner, busy
  );
endinterface

// File: rtl/rps_compare.sv
// rtl/rps_compare.sv - combinational round decision for two legal moves
module rps_compare
  import game_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] result
);

  always_comb begin
    if (a == b) begin
      result = RES_TIE;
    end else if (a == beater_of(b)) begin
      result = RES_P1;
    end else begin
      result = RES_P2;
    end
  end

endmodule

// File: rtl/round_judge.sv
// rtl/round_judge.sv - match referee: move collection, CPU requests, scoring
module round_judge
  import game_pkg::*;
#(
  parameter int WIN_SCORE = 3,
  parameter int SCORE_W   = 3,
  parameter int CPU_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  round_judge_if.slave  bus
);

  localparam int CNT_W = (CPU_LAT > 1) ? $clog2(CPU_LAT) : 1;
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   LAT_LAST = CNT_W'(CPU_LAT - 1);

  state_e             state, state_nxt;
  logic               p1_have, p1_have_nxt;
  logic               p2_have, p2_have_nxt;
  logic [1:0]         p1_mv, p1_mv_nxt;
  logic [1:0]         p2_mv, p2_mv_nxt;
  logic               is_cpu, is_cpu_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         res, res_nxt;
  logic               rv, rv_nxt;
  logic [SCORE_W-1:0] s1, s1_nxt;
  logic [SCORE_W-1:0] s2, s2_nxt;
  logic [1:0]         win, win_nxt;
  logic [1:0]         cmp;

  rps_compare u_cmp (
    .a      (p1_mv),
    .b      (p2_mv),
    .result (cmp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      p1_have <= 1'b0;
      p2_have <= 1'b0;
      p1_mv   <= 2'b00;
      p2_mv   <= 2'b00;
      is_cpu  <= 1'b0;
      cnt     <= '0;
      res     <= RES_NONE;
      rv      <= 1'b0;
      s1      <= '0;
      s2      <= '0;
      win     <= 2'b00;
    end else begin
      state   <= state_nxt;
      p1_have <= p1_have_nxt;
      p2_have <= p2_have_nxt;
      p1_mv   <= p1_mv_nxt;
      p2_mv   <= p2_mv_nxt;
      is_cpu  <= is_cpu_nxt;
      cnt     <= cnt_nxt;
      res     <= res_nxt;
      rv      <= rv_nxt;
      s1      <= s1_nxt;
      s2      <= s2_nxt;
      win     <= win_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    p1_have_nxt = p1_have;
    p2_have_nxt = p2_have;
    p1_mv_nxt   = p1_mv;
    p2_mv_nxt   = p2_mv;
    is_cpu_nxt  = is_cpu;
    cnt_nxt     = cnt;
    res_nxt     = res;
    rv_nxt      = 1'b0;
    s1_nxt      = s1;
    s2_nxt      = s2;
    win_nxt     = win;

    // start from any state (re)opens a match and aborts a round in flight
    if (bus.start) begin
      state_nxt   = S_COLLECT;
      p1_have_nxt = 1'b0;
      p2_have_nxt = 1'b0;
      is_cpu_nxt  = bus.p2_is_cpu;
      cnt_nxt     = '0;
      s1_nxt      = '0;
      s2_nxt      = '0;
      win_nxt     = 2'b00;
    end else begin
      case (state)
        S_COLLECT: begin
          if (p1_have && p2_have) begin
            state_nxt = S_JUDGE;
          end else begin
            if (!p1_have && bus.p1_valid && is_legal(bus.p1_move)) begin
              p1_have_nxt = 1'b1;
              p1_mv_nxt   = bus.p1_move;
            end
            if (!is_cpu && !p2_have && bus.p2_valid && is_legal(bus.p2_move)) begin
              p2_have_nxt = 1'b1;
              p2_mv_nxt   = bus.p2_move;
            end
            if (is_cpu && p1_have) begin
              state_nxt = S_CPU_REQ;
            end
          end
        end

        S_CPU_REQ: begin
          cnt_nxt   = '0;
          state_nxt = S_CPU_WAIT;
        end

        S_CPU_WAIT: begin
          if (cnt == LAT_LAST) begin
            if (bus.cpu_move == ILLEGAL) begin
              state_nxt = S_CPU_REQ;
            end else begin
              p2_have_nxt = 1'b1;
              p2_mv_nxt   = bus.cpu_move;
              state_nxt   = S_COLLECT;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        S_JUDGE: begin
          res_nxt     = cmp;
          rv_nxt      = 1'b1;
          p1_have_nxt = 1'b0;
          p2_have_nxt = 1'b0;
          if (cmp == RES_P1 && s1 < WIN) begin
            s1_nxt = s1 + SCORE_W'(1);
          end
          if (cmp == RES_P2 && s2 < WIN) begin
            s2_nxt = s2 + SCORE_W'(1);
          end
          if (s1_nxt == WIN) begin
            state_nxt = S_DONE;
            win_nxt   = RES_P1;
          end else if (s2_nxt == WIN) begin
            state_nxt = S_DONE;
            win_nxt   = RES_P2;
          end else begin
            state_nxt = S_COLLECT;
          end
        end

        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // Decoded from state so an async reset drops them at once
  assign bus.cpu_en       = (state == S_CPU_REQ);
  assign bus.game_over    = (state == S_DONE);
  assign bus.busy         = (state != S_IDLE) && (state != S_DONE);
  assign bus.round_result = res;
  assign bus.result_valid = rv;
  assign bus.p1_score     = s1;
  assign bus.p2_score     = s2;
  assign bus.winner       = win;

endmodule
